// File: rtl/cycpuf_ro_eval_if.sv
// Request/result bus of the ring-oscillator evaluation stage.
// The requester (master) issues a challenge and receives the response bit,
// tie flag and both raw edge counts back from the evaluator (slave).
interface cycpuf_ro_eval_if #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 2
);
    logic             start;
    logic [IDX_W-1:0] chal_a;
    logic [IDX_W-1:0] chal_b;
    logic             busy;
    logic             done;
    logic             resp;
    logic             tie;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output start, chal_a, chal_b,
        input  busy, done, resp, tie, cnt_a, cnt_b
    );

    modport slave (
        input  start, chal_a, chal_b,
        output busy, done, resp, tie, cnt_a, cnt_b
    );
endinterface

// File: rtl/cycpuf_ro_eval.sv
// Evaluation stage for the CycROPUF ring-oscillator bank.
// A challenge selects two oscillators. Both are enabled for a settle period
// and then for a counting window, during which the rising edges of each
// clk-registered oscillator output are counted. The two counts are then
// compared to form one response bit and a tie flag.
// Indices that fall outside the bank behave like an oscillator stuck at 0.
module cycpuf_ro_eval #(
    parameter int NUM_RO     = 4,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int WINDOW     = 1024,
    parameter int IDX_W      = $clog2(NUM_RO)
) (
    input  logic              clk,
    input  logic              rst,
    cycpuf_ro_eval_if.slave   bus,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en
);

    // One timer serves both phases, so it is sized for the longer one.
    localparam int TMR_MAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W:0]   NUM_RO_L    = (IDX_W + 1)'(NUM_RO);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        CMP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sel_a;
    logic [IDX_W-1:0] sel_b;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] ctr_a;
    logic [CNT_W-1:0] ctr_b;
    logic             hist_a;
    logic             hist_b;

    logic             raw_a;
    logic             raw_b;
    logic             edge_a;
    logic             edge_b;
    logic [CNT_W-1:0] nxt_a;
    logic [CNT_W-1:0] nxt_b;

    // Enable pattern for a challenge pair; out-of-range indices enable nothing.
    function automatic logic [NUM_RO-1:0] en_mask(
        input logic [IDX_W-1:0] a,
        input logic [IDX_W-1:0] b
    );
        logic [NUM_RO-1:0] m;
        m = '0;
        if ({1'b0, a} < NUM_RO_L) begin
            m[a] = 1'b1;
        end
        if ({1'b0, b} < NUM_RO_L) begin
            m[b] = 1'b1;
        end
        return m;
    endfunction

    // Select the latched oscillators, treating a nonexistent one as constant 0.
    always_comb begin
        raw_a = 1'b0;
        raw_b = 1'b0;
        if ({1'b0, sel_a} < NUM_RO_L) begin
            raw_a = ro_in[sel_a];
        end
        if ({1'b0, sel_b} < NUM_RO_L) begin
            raw_b = ro_in[sel_b];
        end
    end

    // Rising-edge detection against the previous sample and saturating next counts.
    always_comb begin
        edge_a = raw_a & ~hist_a;
        edge_b = raw_b & ~hist_b;
        nxt_a  = ctr_a;
        nxt_b  = ctr_b;
        if (edge_a && (ctr_a != {CNT_W{1'b1}})) begin
            nxt_a = ctr_a + 1'b1;
        end
        if (edge_b && (ctr_b != {CNT_W{1'b1}})) begin
            nxt_b = ctr_b + 1'b1;
        end
    end

    // Evaluation sequencer with registered enables, status and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_a     <= '0;
            sel_b     <= '0;
            timer     <= '0;
            ctr_a     <= '0;
            ctr_b     <= '0;
            hist_a    <= 1'b0;
            hist_b    <= 1'b0;
            ro_en     <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.resp  <= 1'b0;
            bus.tie   <= 1'b0;
            bus.cnt_a <= '0;
            bus.cnt_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sel_a    <= bus.chal_a;
                        sel_b    <= bus.chal_b;
                        ctr_a    <= '0;
                        ctr_b    <= '0;
                        timer    <= SETTLE_LOAD;
                        ro_en    <= en_mask(bus.chal_a, bus.chal_b);
                        bus.busy <= 1'b1;
                        state    <= SETTLE;
                    end
                end

                SETTLE: begin
                    // Sampling here primes the edge history so the first
                    // counting cycle sees no edge from a signal already high.
                    hist_a <= raw_a;
                    hist_b <= raw_b;
                    if (timer == '0) begin
                        timer <= WINDOW_LOAD;
                        state <= COUNT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                COUNT: begin
                    hist_a <= raw_a;
                    hist_b <= raw_b;
                    ctr_a  <= nxt_a;
                    ctr_b  <= nxt_b;
                    if (timer == '0) begin
                        // Results are registered from the final counts so they
                        // appear together with done in the compare cycle.
                        ro_en     <= '0;
                        bus.done  <= 1'b1;
                        bus.cnt_a <= nxt_a;
                        bus.cnt_b <= nxt_b;
                        bus.resp  <= (nxt_a > nxt_b);
                        bus.tie   <= (nxt_a == nxt_b);
                        state     <= CMP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                CMP: begin
                    ro_en    <= '0;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    ro_en    <= '0;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycpuf_ro_eval.sv
// Testbench for cycpuf_ro_eval.
// Two instances share the oscillator outputs: d0 uses a short 24-cycle window
// with 16-bit counters, d1 a 64-cycle window with 4-bit counters to reach
// saturation. The oscillator waveform is generated ahead of time into an
// array, so each issued challenge can be evaluated immediately by counting
// rising edges inside its window; the expected result is queued and a
// per-cycle monitor checks busy, enables, done and the held results.
module tb_cycpuf_ro_eval;

    localparam int NUM_RO  = 4;
    localparam int IDX_W   = 2;
    localparam int S       = 8;
    localparam int W0      = 24;
    localparam int W1      = 64;
    localparam int CW0     = 16;
    localparam int CW1     = 4;
    localparam int PAT_LEN = 4096;

    typedef struct {
        int         n;
        int         done_cyc;
        int         ca;
        int         cb;
        bit         resp;
        bit         tie;
        logic [3:0] en;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ro_in;
    logic [3:0] ro_en0;
    logic [3:0] ro_en1;

    logic [3:0] pat [PAT_LEN];
    exp_t       q0 [$];
    exp_t       q1 [$];
    exp_t       last0;
    exp_t       last1;
    int         cyc;
    int         total;
    int         bad;
    bit         mon_on;

    cycpuf_ro_eval_if #(.CNT_W(CW0), .IDX_W(IDX_W)) bus0 ();
    cycpuf_ro_eval_if #(.CNT_W(CW1), .IDX_W(IDX_W)) bus1 ();

    cycpuf_ro_eval #(
        .NUM_RO(NUM_RO), .CNT_W(CW0), .SETTLE_CYC(S), .WINDOW(W0), .IDX_W(IDX_W)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .ro_in(ro_in), .ro_en(ro_en0)
    );

    cycpuf_ro_eval #(
        .NUM_RO(NUM_RO), .CNT_W(CW1), .SETTLE_CYC(S), .WINDOW(W1), .IDX_W(IDX_W)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .ro_in(ro_in), .ro_en(ro_en1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40) begin
                $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
            end
        end
    endtask

    // Rising edges of one oscillator seen during the counting window of a
    // challenge issued in cycle n, clamped to the counter's maximum.
    function automatic int count_edges(input int n, input int idx, input int w, input int cw);
        int c;
        int lim;
        c = 0;
        if (idx >= NUM_RO) begin
            return 0;
        end
        for (int j = n + S + 1; j <= n + S + w; j++) begin
            if (pat[j][idx] && !pat[j-1][idx]) begin
                c++;
            end
        end
        lim = (1 << cw) - 1;
        return (c > lim) ? lim : c;
    endfunction

    function automatic exp_t model(input int n, input int a, input int b, input int w, input int cw);
        exp_t e;
        e.n        = n;
        e.done_cyc = n + S + w + 1;
        e.ca       = count_edges(n, a, w, cw);
        e.cb       = count_edges(n, b, w, cw);
        e.resp     = (e.ca > e.cb);
        e.tie      = (e.ca == e.cb);
        e.en       = 4'b0000;
        if (a < NUM_RO) e.en[a] = 1'b1;
        if (b < NUM_RO) e.en[b] = 1'b1;
        return e;
    endfunction

    function automatic exp_t zero_res();
        exp_t e;
        e.n = 0; e.done_cyc = 0; e.ca = 0; e.cb = 0;
        e.resp = 1'b0; e.tie = 1'b0; e.en = 4'b0000;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ro_in = pat[cyc];
    endtask

    // Rewrite the not-yet-applied part of the oscillator waveform.
    // mode 0: periodic (periods 4,6,5,7), 1: constant high,
    // mode 2: toggle every cycle, 3: random.
    task automatic fill(input int mode);
        int per [4];
        int ph  [4];
        per = '{4, 6, 5, 7};
        for (int i = 0; i < 4; i++) ph[i] = $urandom_range(0, 11);
        for (int j = cyc + 1; j < PAT_LEN && j <= cyc + 300; j++) begin
            for (int i = 0; i < 4; i++) begin
                case (mode)
                    0:       pat[j][i] = (((j + ph[i]) % per[i]) < (per[i] / 2));
                    1:       pat[j][i] = 1'b1;
                    2:       pat[j][i] = ((j % 2) == 0);
                    default: pat[j][i] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    endtask

    // Pulse start on one instance; queue the expected result if it should be accepted.
    task automatic apply_stimulus(input int d, input int a, input int b, input bit accept);
        if (d == 0) begin
            bus0.start  = 1'b1;
            bus0.chal_a = IDX_W'(a);
            bus0.chal_b = IDX_W'(b);
            if (accept) q0.push_back(model(cyc, a, b, W0, CW0));
        end else begin
            bus1.start  = 1'b1;
            bus1.chal_a = IDX_W'(a);
            bus1.chal_b = IDX_W'(b);
            if (accept) q1.push_back(model(cyc, a, b, W1, CW1));
        end
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        int k;
        k = 0;
        while (((d == 0) ? q0.size() : q1.size()) > 0 && k < budget) begin
            tick();
            k++;
        end
        if (((d == 0) ? q0.size() : q1.size()) > 0) begin
            check($sformatf("d%0d.timeout", d), 32'd1, 32'd0);
            if (d == 0) q0.delete(); else q1.delete();
        end
    endtask

    // Per-cycle comparison of one instance against the head of its queue.
    task automatic check_output(input int d, input logic busy, input logic done,
                                input logic resp, input logic tie,
                                input logic [31:0] ca, input logic [31:0] cb,
                                input logic [3:0] en);
        exp_t f;
        exp_t lr;
        bit   has;
        bit   in_busy;
        bit   in_en;
        bit   at_done;
        has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        f   = zero_res();
        if (has) f = (d == 0) ? q0[0] : q1[0];
        in_busy = has && cyc >= f.n + 1 && cyc <= f.done_cyc;
        in_en   = has && cyc >= f.n + 1 && cyc <  f.done_cyc;
        at_done = has && cyc == f.done_cyc;
        check($sformatf("d%0d.busy", d), 32'(busy), 32'(in_busy));
        check($sformatf("d%0d.ro_en", d), 32'(en), in_en ? 32'(f.en) : 32'd0);
        check($sformatf("d%0d.done", d), 32'(done), 32'(at_done));
        if (has && (done === 1'b1 || cyc >= f.done_cyc)) begin
            if (cyc == f.done_cyc) begin
                if (d == 0) last0 = f; else last1 = f;
            end
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        lr = (d == 0) ? last0 : last1;
        check($sformatf("d%0d.cnt_a", d), ca, 32'(lr.ca));
        check($sformatf("d%0d.cnt_b", d), cb, 32'(lr.cb));
        check($sformatf("d%0d.resp", d), 32'(resp), 32'(lr.resp));
        check($sformatf("d%0d.tie", d), 32'(tie), 32'(lr.tie));
    endtask

    // Monitor: sample both instances mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_on) begin
            check_output(0, bus0.busy, bus0.done, bus0.resp, bus0.tie,
                         32'(bus0.cnt_a), 32'(bus0.cnt_b), ro_en0);
            check_output(1, bus1.busy, bus1.done, bus1.resp, bus1.tie,
                         32'(bus1.cnt_a), 32'(bus1.cnt_b), ro_en1);
        end
    end

    // Guard against a hung run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d;
        int a;
        int b;
        total  = 0;
        bad    = 0;
        cyc    = 0;
        mon_on = 1'b0;
        last0  = zero_res();
        last1  = zero_res();
        for (int j = 0; j < PAT_LEN; j++) pat[j] = 4'b0000;
        ro_in       = pat[0];
        rst         = 1'b1;
        bus0.start  = 1'b0;
        bus0.chal_a = '0;
        bus0.chal_b = '0;
        bus1.start  = 1'b0;
        bus1.chal_a = '0;
        bus1.chal_b = '0;

        repeat (3) tick();
        rst    = 1'b0;
        mon_on = 1'b1;
        $display("[TB] reset released");

        // Periodic oscillators: A faster than B, then swapped, then same index.
        fill(0);
        repeat (4) tick();
        apply_stimulus(0, 0, 1, 1'b1);
        wait_idle(0, 100);
        apply_stimulus(0, 1, 0, 1'b1);
        wait_idle(0, 100);
        apply_stimulus(0, 2, 2, 1'b1);
        wait_idle(0, 100);

        // A second start during COUNT with another challenge must be ignored.
        fill(0);
        apply_stimulus(0, 0, 1, 1'b1);
        repeat (S + 5) tick();
        apply_stimulus(0, 3, 2, 1'b0);
        wait_idle(0, 100);

        // Reset in the middle of COUNT aborts without done.
        fill(3);
        apply_stimulus(0, 0, 1, 1'b1);
        repeat (S + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        last0 = zero_res();
        last1 = zero_res();
        repeat (3) tick();
        apply_stimulus(0, 2, 3, 1'b1);
        wait_idle(0, 100);

        // Oscillators held high from before start: no edge is counted.
        fill(1);
        repeat (3) tick();
        apply_stimulus(0, 0, 1, 1'b1);
        wait_idle(0, 100);

        // Narrow counters saturate when both inputs toggle every cycle.
        fill(2);
        repeat (2) tick();
        apply_stimulus(1, 0, 1, 1'b1);
        wait_idle(1, 200);

        // Randomized challenges and waveforms on both instances.
        for (int it = 0; it < 10; it++) begin
            fill(($urandom_range(0, 1) == 0) ? 3 : 2);
            repeat ($urandom_range(0, 3)) tick();
            d = $urandom_range(0, 1);
            a = $urandom_range(0, NUM_RO - 1);
            b = $urandom_range(0, NUM_RO - 1);
            apply_stimulus(d, a, b, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 20)) tick();
                apply_stimulus(d, $urandom_range(0, NUM_RO - 1),
                               $urandom_range(0, NUM_RO - 1), 1'b0);
            end
            wait_idle(d, 200);
        end

        repeat (3) tick();
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cycpuf_ro_eval.md
# cycpuf_ro_eval

Evaluation stage directly downstream of the CycROPUF ring-oscillator bank. On a challenge it enables two selected oscillators for a fixed window and counts the rising edges of each `out`. It then compares the two counts and returns one response bit, a tie flag and both raw counts. It drives the oscillators' `en` inputs and consumes their clk-registered `out` signals.

## Interface
- `NUM_RO`, default 4: number of oscillators in the bank; must be ≥2.
- `CNT_W`, default 16: edge-counter width.
- `SETTLE_CYC`, default 8: cycles the oscillators run before counting starts; must be ≥1.
- `WINDOW`, default 1024: counting window length in cycles; must be ≥1.
- `IDX_W`, default `$clog2(NUM_RO)`: width of the challenge index fields (derived).

- `clk` in 1: single clock. The oscillator bank's output registers use the same clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request an evaluation. Sampled only in IDLE.
- `chal_a` in IDX_W: index of oscillator A.
- `chal_b` in IDX_W: index of oscillator B.
- `ro_in` in NUM_RO: `out` of each oscillator, already synchronous to `clk`.
- `ro_en` out NUM_RO: `en` to each oscillator.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the result becomes valid.
- `resp` out 1: response bit, 1 when cnt_a > cnt_b.
- `tie` out 1: 1 when cnt_a == cnt_b.
- `cnt_a` out CNT_W: final edge count of oscillator A.
- `cnt_b` out CNT_W: final edge count of oscillator B.

## Operation
- Reset values: state=IDLE; `ro_en`=0; `busy`, `done`, `resp`, `tie`=0; `cnt_a`, `cnt_b`=0; internal counters, timer and edge-history registers=0.
- FSM states: IDLE, SETTLE, COUNT, CMP.
- IDLE
  - When `start`=1: latch `chal_a`/`chal_b` into `sel_a`/`sel_b`, clear both counters, load the timer with SETTLE_CYC−1, and go to SETTLE.
  - Otherwise remain in IDLE.
- SETTLE
  - `ro_en[sel_a]` and `ro_en[sel_b]`=1; all other enable bits=0.
  - Decrement the timer each cycle.
  - When the timer is 0: load WINDOW−1 and go to COUNT.
- COUNT
  - Enables as in SETTLE.
  - Each counter increments in a cycle where its selected `ro_in` is 1 and its history register is 0.
  - History registers sample the selected `ro_in` every cycle in SETTLE and COUNT. The first COUNT cycle therefore compares against the last SETTLE sample, so no spurious edge is counted.
  - When the timer is 0: go to CMP.
- CMP
  - `ro_en`=0.
  - Copy the counters to `cnt_a`/`cnt_b`; `resp` = (count A > count B); `tie` = (count A == count B).
  - Pulse `done`; go to IDLE.
- Counters saturate at 2^CNT_W−1 and never wrap. Comparison is unsigned.
- `chal_a` == `chal_b`: the evaluation runs normally with one oscillator enabled; the result is `tie`=1, `resp`=0.
- An index ≥ NUM_RO counts as an oscillator stuck at 0: its counter stays 0 and no enable bit is driven for it.
- `start` while busy is ignored; no queuing.
- `rst` at any point forces all reset values in the next cycle, including `ro_en`=0, and aborts the evaluation with no `done`.
- `resp`/`tie`/`cnt_a`/`cnt_b` hold their values until the next CMP or `rst`.

## Timing
- `start` sampled high at edge T:
  - SETTLE covers cycles T+1 … T+SETTLE_CYC.
  - COUNT covers T+SETTLE_CYC+1 … T+SETTLE_CYC+WINDOW.
  - CMP at T+SETTLE_CYC+WINDOW+1: `done`=1 and the results are visible in that same cycle.
- Total latency from `start` to `done` is SETTLE_CYC+WINDOW+1 cycles. `busy` is high for exactly that many cycles.
- The earliest next accepted `start` is the cycle after `done`.
- `ro_en` rises in the cycle after `start` is sampled and falls in the CMP cycle.

## Test plan
- Defaults except WINDOW=24, SETTLE_CYC=8, chal_a=0, chal_b=1. ro_in[0] rises every 4 cycles and ro_in[1] rises every 6 cycles throughout -> `done` 33 cycles after `start`, cnt_a=6, cnt_b=4, resp=1, tie=0, `busy` high for 33 cycles.
- Same setup with chal_a=1, chal_b=0 -> cnt_a=4, cnt_b=6, resp=0, tie=0. With chal_a=chal_b=2 -> tie=1, resp=0, and `ro_en`=4'b0100 during the run.
- CNT_W=4, WINDOW=64, both selected inputs toggling every cycle (32 rising edges each) -> cnt_a=cnt_b=15 (saturated), tie=1, resp=0.
- `start` re-asserted during COUNT and a different challenge applied -> ignored; the result matches the original challenge and exactly one `done` occurs.
- `rst` asserted mid-COUNT -> next cycle `ro_en`=0, `busy`=0, cnt_a=cnt_b=0, no `done`. A following `start` completes normally.
- ro_in held constant 1 from before `start` -> counts=0, tie=1 (no spurious edge at the SETTLE-to-COUNT boundary).
